prog_feeder: RTL and testbench
==============================

Name: prog_feeder

Overview:
- Upstream instruction source for the processor core. Buffers 16-bit program words loaded from the board switches, then issues them one at a time on DIN using the core's Run/Done handshake.
- Holds the extra immediate word of a move-immediate instruction on DIN until the core signals Done.
- Sits between the switch/load logic and the core's DIN/Run inputs. Turns manual single-stepping into buffered, sequenced execution.

Parameters:
- DEPTH, 8, number of 16-bit word slots in the program FIFO; power of two, at least 2.
- IMM_OPCODE, 3'b001, value of DIN[15:13] that marks an instruction taking one trailing immediate word.
- TIMEOUT, 255, maximum cycles to wait for Done after a Run pulse before flagging an error.

Ports:
- Clock  in  1  system clock; everything samples on the rising edge.
- Resetn  in  1  asynchronous active-low reset.
- WrData  in  16  program word to enqueue.
- Load  in  1  enqueue strobe; one word is pushed per high cycle.
- Start  in  1  level; while high, execution is enabled.
- Done  in  1  completion strobe from the processor core.
- DIN  out  16  word presented to the core.
- Run  out  1  single-cycle issue pulse to the core.
- Busy  out  1  high in any state other than IDLE.
- Full  out  1  FIFO count equals DEPTH.
- Empty  out  1  FIFO count equals 0.
- Count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- InstrCount  out  16  instructions completed since reset; wraps from 16'hFFFF to 0.
- Overflow  out  1  sticky flag: a push was dropped.
- Error  out  1  sticky flag: a Done timeout occurred.

Behaviour:
- Reset (asynchronous, Resetn=0):
  - FIFO emptied; pointers and Count set to 0.
  - State returns to IDLE.
  - DIN=0, Run=0, InstrCount=0, Overflow=0, Error=0.
  - Applies mid-operation; no partial instruction survives reset.
- FIFO:
  - Push occurs when Load=1 and (not Full, or a pop occurs in the same cycle).
  - Load=1 while Full with no pop: word dropped, Overflow set to 1.
  - Pointers wrap modulo DEPTH.
  - Count, Full and Empty reflect the registered state after the edge.
- Readiness rule, "head ready":
  - Count>=1, and
  - if head[15:13]==IMM_OPCODE, Count>=2 (the immediate word must already be buffered).
- States:
  - IDLE:
    - Run=0; DIN holds its last value.
    - If Start=1 and head ready: go to ISSUE.
  - ISSUE (1 cycle):
    - DIN=head word, Run=1; pop the head.
    - If opcode==IMM_OPCODE: go to IMM, else go to WAIT.
    - Timeout counter cleared.
  - IMM:
    - DIN=new head word (the immediate), Run=0.
    - On Done=1: pop the immediate, InstrCount+1, go to NEXT.
  - WAIT:
    - DIN holds the instruction word, Run=0.
    - On Done=1: InstrCount+1, go to NEXT.
  - NEXT (1 cycle):
    - Run=0.
    - If Start=1 and head ready: go to ISSUE, else go to IDLE.
- Timeout:
  - In IMM or WAIT, the counter increments each cycle that Done=0.
  - When the counter reaches TIMEOUT: Error=1, go to IDLE.
  - In IMM, the unconsumed immediate is popped on the timeout.
- Run is never high on two consecutive cycles. Minimum issue spacing is 3 cycles (ISSUE, WAIT/IMM with Done, NEXT).
- Done outside IMM/WAIT is ignored.
- Start dropping mid-instruction does not abort it; the feeder stops at NEXT.
- Simultaneous Load and pop: both take effect; Count is unchanged.
- Overflow and Error clear only on reset.

Test Plan:
- Reset, Load 3 words (16'h0400, 16'h2200, 16'h0005), assert Start, core model returns Done 2 cycles after Run:
  - Run pulses exactly twice.
  - DIN=16'h0400 during the first WAIT.
  - DIN=16'h2200 then 16'h0005 while the second instruction is pending.
  - InstrCount=2, Empty=1, state ends IDLE.
- Load only 16'h2200 (IMM opcode) with Start=1:
  - No Run is issued.
- Load 16'h0007 to the same FIFO:
  - Run is issued within 2 cycles; the immediate 16'h0007 is held on DIN until Done.
- Load DEPTH+1 words with Start=0:
  - Count=8, Full=1, Overflow=1.
  - The ninth word is absent when the FIFO is drained.
- Issue an instruction and never assert Done:
  - Error=1 exactly TIMEOUT cycles after WAIT is entered; state returns to IDLE; InstrCount unchanged.
- Pull Resetn low during WAIT with Count=4:
  - Immediately Run=0, DIN=0, Count=0, Empty=1, InstrCount=0.
  - Flags clear; no Run pulse after release until new loads arrive.

Source files
------------

// File: rtl/prog_feeder_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | prog_feeder_if : load-side and core-side signals of the program feeder |
// | Revision 1.0                                                           |
// +-----------------------------------------------------------------------+
interface prog_feeder_if #(
  parameter int DEPTH = 8
);
  localparam int c_CW = $clog2(DEPTH) + 1;

  logic [15:0]     WrData;
  logic            Load;
  logic            Start;
  logic            Done;
  logic [15:0]     DIN;
  logic            Run;
  logic            Busy;
  logic            Full;
  logic            Empty;
  logic [c_CW-1:0] Count;
  logic [15:0]     InstrCount;
  logic            Overflow;
  logic            Error;

  modport master (
    output WrData, Load, Start, Done,
    input  DIN, Run, Busy, Full, Empty, Count, InstrCount, Overflow, Error
  );

  modport slave (
    input  WrData, Load, Start, Done,
    output DIN, Run, Busy, Full, Empty, Count, InstrCount, Overflow, Error
  );
endinterface
`default_nettype wire

// File: rtl/prog_feeder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | prog_feeder : buffers program words and issues them on DIN with Run/Done |
// | Revision 1.0                                                           |
// +-----------------------------------------------------------------------+
module prog_feeder #(
  parameter int         DEPTH      = 8,
  parameter logic [2:0] IMM_OPCODE = 3'b001,
  parameter int         TIMEOUT    = 255
) (
  input  logic         Clock,
  input  logic         Resetn,
  prog_feeder_if.slave bus
);
  localparam int              c_AW    = $clog2(DEPTH);
  localparam int              c_CW    = c_AW + 1;
  localparam int              c_TW    = $clog2(TIMEOUT + 1);
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);
  localparam logic [c_TW-1:0] c_TLAST = c_TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_IMM   = 3'd2,
    S_WAIT  = 3'd3,
    S_NEXT  = 3'd4
  } state_t;

  state_t r_state, w_state_nxt;

  logic [15:0]     r_mem [DEPTH];
  logic [c_AW-1:0] r_wptr;
  logic [c_AW-1:0] r_rptr;
  logic [c_AW-1:0] w_rptr_p1;
  logic [c_CW-1:0] r_count;
  logic [15:0]     r_din;
  logic [15:0]     r_instr_cnt;
  logic [c_TW-1:0] r_tmo;
  logic            r_ovf;
  logic            r_err;

  logic [15:0] w_head;
  logic [15:0] w_second;
  logic        w_full;
  logic        w_empty;
  logic        w_head_ready;
  logic        w_push;
  logic        w_pop;
  logic        w_drop;
  logic        w_done_ok;
  logic        w_tmo_hit;

  assign w_rptr_p1 = r_rptr + c_AW'(1);
  assign w_head    = r_mem[r_rptr];
  assign w_second  = r_mem[w_rptr_p1];
  assign w_full    = (r_count == c_DEPTH);
  assign w_empty   = (r_count == '0);

  // An immediate-taking instruction waits until its trailing word is buffered
  assign w_head_ready = !w_empty &&
                        ((w_head[15:13] != IMM_OPCODE) || (r_count >= c_CW'(2)));

  assign w_push = bus.Load && (!w_full || w_pop);
  assign w_drop = bus.Load && w_full && !w_pop;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_done_ok   = 1'b0;
    w_tmo_hit   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.Start && w_head_ready) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        w_pop       = 1'b1;
        w_state_nxt = (w_head[15:13] == IMM_OPCODE) ? S_IMM : S_WAIT;
      end
      S_IMM: begin
        if (bus.Done) begin
          w_pop       = 1'b1;
          w_done_ok   = 1'b1;
          w_state_nxt = S_NEXT;
        end else if (r_tmo == c_TLAST) begin
          // the abandoned immediate must not be mistaken for an instruction
          w_pop       = 1'b1;
          w_tmo_hit   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (bus.Done) begin
          w_done_ok   = 1'b1;
          w_state_nxt = S_NEXT;
        end else if (r_tmo == c_TLAST) begin
          w_tmo_hit   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_NEXT: begin
        w_state_nxt = (bus.Start && w_head_ready) ? S_ISSUE : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge Clock) begin
    if (w_push) r_mem[r_wptr] <= bus.WrData;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_AW'(1);
      if (w_pop)  r_rptr <= w_rptr_p1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_din       <= '0;
      r_instr_cnt <= '0;
      r_tmo       <= '0;
      r_ovf       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // The immediate is the head once the opcode pops at the end of ISSUE
      if (w_state_nxt == S_ISSUE)                          r_din <= w_head;
      else if (r_state == S_ISSUE && w_state_nxt == S_IMM) r_din <= w_second;

      if (r_state == S_ISSUE)
        r_tmo <= '0;
      else if ((r_state == S_IMM || r_state == S_WAIT) && !bus.Done)
        r_tmo <= r_tmo + c_TW'(1);

      if (w_done_ok) r_instr_cnt <= r_instr_cnt + 16'd1;
      if (w_drop)    r_ovf       <= 1'b1;
      if (w_tmo_hit) r_err       <= 1'b1;
    end
  end

  assign bus.DIN        = r_din;
  assign bus.Run        = (r_state == S_ISSUE);
  assign bus.Busy       = (r_state != S_IDLE);
  assign bus.Full       = w_full;
  assign bus.Empty      = w_empty;
  assign bus.Count      = r_count;
  assign bus.InstrCount = r_instr_cnt;
  assign bus.Overflow   = r_ovf;
  assign bus.Error      = r_err;
endmodule
`default_nettype wire

// File: tb/tb_prog_feeder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_prog_feeder : scoreboard bench for the program feeder               |
// | Revision 1.0                                                           |
// +-----------------------------------------------------------------------+
module tb_prog_feeder;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 255;

  logic Clock;
  logic Resetn;
  logic done_en;

  prog_feeder_if #(.DEPTH(DEPTH)) bus ();

  prog_feeder #(
    .DEPTH      (DEPTH),
    .IMM_OPCODE (3'b001),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected FIFO contents in issue order
  logic [15:0] sb[$];
  logic [15:0] exp_hold;
  logic        have_hold  = 1'b0;
  logic        prev_run   = 1'b0;
  int          run_pulses = 0;

  always @(negedge Clock) begin
    if (bus.Run) begin
      logic [15:0] w;
      run_pulses++;
      check("run_spacing", 32'(prev_run), 32'd0);
      check("sb_nonempty_at_run", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        w = sb.pop_front();
        check("issue_din", 32'(bus.DIN), 32'(w));
        if (w[15:13] == 3'b001) begin
          check("imm_buffered", 32'(sb.size() != 0), 32'd1);
          exp_hold = (sb.size() != 0) ? sb.pop_front() : 16'h0;
        end else begin
          exp_hold = w;
        end
        have_hold = 1'b1;
      end
    end else if (bus.Busy && have_hold) begin
      check("din_hold", 32'(bus.DIN), 32'(exp_hold));
    end
    prev_run = bus.Run;
  end

  // Core model: Done pulses two cycles after an observed Run
  initial begin
    bus.Done = 1'b0;
    forever begin
      @(negedge Clock);
      if (bus.Run && done_en) begin
        @(posedge Clock);
        @(posedge Clock);
        #1 bus.Done = 1'b1;
        @(posedge Clock);
        #1 bus.Done = 1'b0;
      end
    end
  end

  task automatic load(input logic [15:0] w);
    bus.WrData = w;
    bus.Load   = 1'b1;
    if (sb.size() < DEPTH) sb.push_back(w);
    @(posedge Clock);
    #1;
    bus.Load = 1'b0;
  endtask

  task automatic wait_instr(input int n, input int budget);
    int k = 0;
    while (bus.InstrCount != 16'(n) && k < budget) begin
      @(posedge Clock);
      #1;
      k++;
    end
    check("instr_count_reached", 32'(bus.InstrCount), 32'(n));
  endtask

  task automatic wait_run(input int budget, output logic seen);
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge Clock);
      if (bus.Run) seen = 1'b1;
    end
  endtask

  initial begin
    int   base;
    logic seen;
    Resetn     = 1'b0;
    done_en    = 1'b1;
    bus.WrData = '0;
    bus.Load   = 1'b0;
    bus.Start  = 1'b0;

    repeat (2) @(posedge Clock);
    #1;
    check("rst_din", 32'(bus.DIN), 32'h0);
    check("rst_run", 32'(bus.Run), 32'h0);
    check("rst_count", 32'(bus.Count), 32'h0);
    check("rst_empty", 32'(bus.Empty), 32'h1);
    check("rst_busy", 32'(bus.Busy), 32'h0);
    check("rst_flags", {30'd0, bus.Overflow, bus.Error}, 32'h0);
    #2 Resetn = 1'b1;

    // Plain instruction followed by a move-immediate
    @(posedge Clock);
    #1;
    load(16'h0400);
    load(16'h2200);
    load(16'h0005);
    check("t1_count", 32'(bus.Count), 32'd3);
    bus.Start = 1'b1;
    wait_instr(2, 40);
    repeat (3) @(posedge Clock);
    #1;
    check("t1_runs", 32'(run_pulses), 32'd2);
    check("t1_empty", 32'(bus.Empty), 32'd1);
    check("t1_idle", 32'(bus.Busy), 32'd0);

    // Lone immediate opcode must wait for its operand
    load(16'h2200);
    repeat (5) @(posedge Clock);
    #1;
    check("t2_no_run", 32'(run_pulses), 32'd2);
    check("t2_count", 32'(bus.Count), 32'd1);
    check("t2_idle", 32'(bus.Busy), 32'd0);
    load(16'h0007);
    base = run_pulses;
    for (int k = 0; k < 2 && run_pulses == base; k++) begin
      @(negedge Clock);
      #1;
    end
    check("t3_run_within_2", 32'(run_pulses), 32'(base + 1));
    wait_instr(3, 20);
    repeat (2) @(posedge Clock);
    #1;
    check("t3_empty", 32'(bus.Empty), 32'd1);

    // Overfill with execution disabled, then drain
    bus.Start = 1'b0;
    for (int i = 0; i <= DEPTH; i++) load(16'h1000 + 16'(i));
    check("t4_count", 32'(bus.Count), 32'd8);
    check("t4_full", 32'(bus.Full), 32'd1);
    check("t4_overflow", 32'(bus.Overflow), 32'd1);
    check("t4_sb_size", 32'(sb.size()), 32'd8);
    base = run_pulses;
    bus.Start = 1'b1;
    wait_instr(3 + DEPTH, 120);
    repeat (3) @(posedge Clock);
    #1;
    check("t4_runs", 32'(run_pulses), 32'(base + DEPTH));
    check("t4_empty", 32'(bus.Empty), 32'd1);
    check("t4_overflow_sticky", 32'(bus.Overflow), 32'd1);

    // Done never arrives
    done_en   = 1'b0;
    bus.Start = 1'b0;
    load(16'h0123);
    bus.Start = 1'b1;
    wait_run(6, seen);
    check("t5_run_seen", 32'(seen), 32'd1);
    @(posedge Clock);
    repeat (TIMEOUT - 1) @(posedge Clock);
    #1;
    check("t5_no_err_early", 32'(bus.Error), 32'd0);
    @(posedge Clock);
    #1;
    check("t5_err", 32'(bus.Error), 32'd1);
    check("t5_idle", 32'(bus.Busy), 32'd0);
    check("t5_instr_unchanged", 32'(bus.InstrCount), 32'd11);

    // Asynchronous reset in WAIT with four words queued
    bus.Start = 1'b0;
    for (int i = 0; i < 5; i++) load(16'h0A01 + 16'(i));
    bus.Start = 1'b1;
    wait_run(6, seen);
    check("t6_run_seen", 32'(seen), 32'd1);
    @(posedge Clock);
    #1;
    check("t6_count4", 32'(bus.Count), 32'd4);
    check("t6_busy", 32'(bus.Busy), 32'd1);
    #2 Resetn = 1'b0;
    sb.delete();
    #1;
    check("t6_run", 32'(bus.Run), 32'd0);
    check("t6_din", 32'(bus.DIN), 32'd0);
    check("t6_count", 32'(bus.Count), 32'd0);
    check("t6_empty", 32'(bus.Empty), 32'd1);
    check("t6_instr", 32'(bus.InstrCount), 32'd0);
    check("t6_flags", {30'd0, bus.Overflow, bus.Error}, 32'd0);
    @(posedge Clock);
    #3 Resetn = 1'b1;
    base = run_pulses;
    repeat (10) @(posedge Clock);
    #1;
    check("t6_no_run_after_reset", 32'(run_pulses), 32'(base));
    check("t6_idle", 32'(bus.Busy), 32'd0);
    done_en = 1'b1;
    load(16'h0B0B);
    wait_instr(1, 20);
    repeat (2) @(posedge Clock);
    #1;
    check("t6_final_empty", 32'(bus.Empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
